// File: rtl/ram_sync_param.sv
// ram_sync_param: single-port synchronous RAM with byte-lane writes, a read-latency
// pipeline and a selectable read-during-write mode. After reset, or on request, the
// block sweeps every word to zero before it accepts accesses.
//
// Parameters:
//   ADDR_W    address width; depth = 2**ADDR_W words
//   DATA_W    word width, a multiple of 8 (BE_W = DATA_W/8 byte lanes)
//   RD_LAT    read latency in clock edges after the accepting edge, 1..4
//   RDW_MODE  same-cycle read+write: 0 = read returns old word, 1 = merged new word
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (flushes reads, restarts the sweep)
//   clr       synchronous request to re-run the zero-clear sweep
//   cs        chip select; accesses are taken only when cs & ready
//   wr, rd    write / read request
//   be        byte-lane write enables, lane i = data bits [8i+7:8i]
//   addr      word address
//   data_in   write data
//   data_out  read data, holds between reads
//   rd_valid  one-cycle pulse marking data_out as a fresh read result
//   ready     clear sweep finished, accesses accepted
module ram_sync_param #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  cs,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  ready
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                ready_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                do_wr;
  logic                do_rd;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged_word;
  logic [DATA_W-1:0]   rd_word;

  logic [DATA_W-1:0]   pipe_data_q [RD_LAT];
  logic [RD_LAT-1:0]   pipe_vld_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                rd_valid_q;

  assign accept   = cs & ready_q;
  assign do_wr    = accept & wr;
  assign do_rd    = accept & rd;
  assign old_word = mem[addr];

  // Word as it will look after this cycle's write: enabled lanes from data_in.
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        merged_word[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  assign rd_word = ((RDW_MODE != 0) && do_wr) ? merged_word : old_word;

  // Storage has no reset; the sweep owns the write port while in StInit.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= '0;
    end else if (do_wr) begin
      mem[addr] <= merged_word;
    end
  end

  // Sweep / run control with registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (clr) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (cnt_q == '1) begin
              state_q <= StRun;
              ready_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (clr) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Read pipeline: stage 0 captures the sampled word on the accepting edge, the
  // output register is loaded RD_LAT edges later. clr does not touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_data_q[i] <= '0;
      end
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      pipe_vld_q[0] <= do_rd;
      if (do_rd) begin
        pipe_data_q[0] <= rd_word;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
      rd_valid_q <= pipe_vld_q[RD_LAT-1];
      if (pipe_vld_q[RD_LAT-1]) begin
        data_out_q <= pipe_data_q[RD_LAT-1];
      end
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign ready    = ready_q;

endmodule
